// File: rtl/pipe_mux.sv
// Multi-channel input mux feeding a single registered output stage with valid/ready handshake.
// Channel choice is either an explicit select or a round-robin search over valid inputs.
module pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_chan
);

    localparam logic [SEL_W:0] LAST_IDX = (SEL_W + 1)'(NUM_IN - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             can_accept;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] chan_data [NUM_IN];

    assign can_accept = !out_valid_q || out_ready;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            // Gated by rst_n so no handshake can be offered while reset is held.
            assign in_ready[gi]  = rst_n && can_accept && grant_valid
                                   && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Round-robin: scan from the farthest offset down so the nearest valid channel wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (MODE == 0) begin
            grant_valid = ({1'b0, sel} <= LAST_IDX);
            grant_idx   = sel;
        end else begin
            for (int off = NUM_IN - 1; off >= 0; off--) begin
                cand = int'(rr_ptr_q) + off;
                if (cand >= NUM_IN) cand = cand - NUM_IN;
                if (in_valid[SEL_W'(cand)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(cand);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_idx == SEL_W'(k)) sel_data = chan_data[k];
        end
    end

    assign transfer = |(in_valid & in_ready);

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_data_d  = sel_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (MODE == 1) begin
                rr_ptr_d = (grant_idx == LAST_IDX[SEL_W-1:0]) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: an explicit-select instance (5 channels) and a round-robin instance
// (4 channels) driven with directed and random stimulus against a cycle-level reference model.
module tb_pipe_mux;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Explicit-select instance, 5 channels
    logic [5*W-1:0] data0;
    logic [4:0]     valid0, ready0;
    logic [2:0]     sel0, ochan0;
    logic [W-1:0]   odata0;
    logic           ovalid0, ordy0;

    // Round-robin instance, 4 channels
    logic [4*W-1:0] data1;
    logic [3:0]     valid1, ready1;
    logic [1:0]     sel1, ochan1;
    logic [W-1:0]   odata1;
    logic           ovalid1, ordy1;

    pipe_mux #(.WIDTH(W), .NUM_IN(5), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_data(data0), .in_valid(valid0), .in_ready(ready0),
        .sel(sel0), .out_data(odata0), .out_valid(ovalid0), .out_ready(ordy0), .out_chan(ochan0)
    );

    pipe_mux #(.WIDTH(W), .NUM_IN(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(data1), .in_valid(valid1), .in_ready(ready1),
        .sel(sel1), .out_data(odata1), .out_valid(ovalid1), .out_ready(ordy1), .out_chan(ochan1)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: what the output register should hold, plus the round-robin start point.
    logic         m_v0, m_v1;
    logic [W-1:0] m_d0, m_d1;
    int           m_c0, m_c1, m_rr1;
    int           g0, g1;
    logic [31:0]  er0, er1;

    function automatic int grant_sel(input logic [2:0] s);
        return (int'(s) < 5) ? int'(s) : -1;
    endfunction

    function automatic int grant_rr(input logic [3:0] v, input int start);
        for (int off = 0; off < 4; off++) begin
            if (v[(start + off) % 4]) return (start + off) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v0 = 1'b0; m_d0 = '0; m_c0 = 0;
        m_v1 = 1'b0; m_d1 = '0; m_c1 = 0; m_rr1 = 0;
    endtask

    task automatic check_all();
        g0  = grant_sel(sel0);
        g1  = grant_rr(valid1, m_rr1);
        er0 = (rst_n && (!m_v0 || ordy0) && g0 >= 0) ? (32'd1 << g0) : 32'd0;
        er1 = (rst_n && (!m_v1 || ordy1) && g1 >= 0) ? (32'd1 << g1) : 32'd0;
        chk("sel_ready", 32'(ready0), er0);
        chk("sel_valid", 32'(ovalid0), 32'(m_v0));
        chk("sel_data",  32'(odata0), 32'(m_d0));
        chk("sel_chan",  32'(ochan0), 32'(m_c0));
        chk("rr_ready",  32'(ready1), er1);
        chk("rr_valid",  32'(ovalid1), 32'(m_v1));
        chk("rr_data",   32'(odata1), 32'(m_d1));
        chk("rr_chan",   32'(ochan1), 32'(m_c1));
        $display("t=%0t sel: ready=%b out=%0d/%0h/%0d  rr: ready=%b out=%0d/%0h/%0d",
                 $time, ready0, ovalid0, odata0, ochan0, ready1, ovalid1, odata1, ochan1);
    endtask

    // Inputs are set just after a falling edge; check, then advance the model across the rising edge.
    task automatic cycle();
        #2;
        check_all();
        @(posedge clk);
        if (er0 != 0 && valid0[g0]) begin
            m_v0 = 1'b1; m_d0 = data0[g0*W +: W]; m_c0 = g0;
        end else if (ordy0) begin
            m_v0 = 1'b0;
        end
        if (er1 != 0 && valid1[g1]) begin
            m_v1 = 1'b1; m_d1 = data1[g1*W +: W]; m_c1 = g1; m_rr1 = (g1 + 1) % 4;
        end else if (ordy1) begin
            m_v1 = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        data0 = '0; valid0 = '0; sel0 = '0; ordy0 = 1'b1;
        data1 = '0; valid1 = '0; sel1 = '0; ordy1 = 1'b1;
        model_reset();

        // Reset state while held
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // Explicit select: 5 then 10
        data0[0*W +: W] = 16'd5;
        data0[1*W +: W] = 16'd10;
        valid0 = 5'b00011; sel0 = 3'd0;
        cycle();
        sel0 = 3'd1;
        cycle();
        valid0 = '0;
        cycle();
        cycle();

        // Backpressure: load 5, hold 3 cycles, then drain and refill in one cycle
        sel0 = 3'd0; valid0 = 5'b00001; ordy0 = 1'b1;
        cycle();
        ordy0 = 1'b0; valid0 = 5'b00011;
        repeat (3) cycle();
        ordy0 = 1'b1; sel0 = 3'd1;
        cycle();
        valid0 = '0;
        cycle();

        // Out-of-range selects grant nothing
        valid0 = 5'b11111;
        for (int s = 5; s < 8; s++) begin
            sel0 = 3'(s);
            cycle();
        end
        valid0 = '0; sel0 = '0;
        cycle();

        // Round-robin over all valid channels
        for (int k = 0; k < 4; k++) data1[k*W +: W] = 16'(100 + k);
        valid1 = 4'hf;
        repeat (5) cycle();
        valid1 = '0;
        cycle();

        // Move pointer to 2 via channel 1, then channels 1 and 3 alternate starting with 3
        valid1 = 4'b0010;
        cycle();
        valid1 = 4'b1010;
        repeat (3) cycle();
        valid1 = '0;
        cycle();

        // Asynchronous reset while holding 10; pointer left nonzero beforehand
        sel0 = 3'd1; valid0 = 5'b00010; ordy0 = 1'b0;
        valid1 = 4'b0010;
        cycle();
        valid0 = '0; valid1 = '0;
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        ordy0 = 1'b1;
        valid1 = 4'hf;
        cycle();
        valid1 = '0;
        cycle();

        // Random traffic on both instances
        for (int n = 0; n < 300; n++) begin
            data0  = {$urandom, $urandom, $urandom};
            data1  = {$urandom, $urandom};
            valid0 = 5'($urandom);
            valid1 = 4'($urandom);
            sel0   = 3'($urandom);
            sel1   = 2'($urandom);
            ordy0  = ($urandom_range(0, 3) != 0);
            ordy1  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of every channel, in bits.
REQ-002 Parameter NUM_IN, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 0: 0 = explicit select, 1 = round-robin arbitration.
REQ-004 Derived localparam SEL_W = $clog2(NUM_IN).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 in_data  input  NUM_IN*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  input  NUM_IN  per-channel valid.
REQ-009 in_ready  output  NUM_IN  per-channel ready; one-hot or all-zero.
REQ-010 sel  input  SEL_W  channel select, used only in MODE 0.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  output register holds a valid word.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_chan  output  SEL_W  index of the channel that produced out_data.

Function
REQ-015 Single output register stage; latency from input transfer to out_valid is exactly 1 cycle.
REQ-016 can_accept = !out_valid || out_ready (combinational).
REQ-017 Input transfer on channel k occurs when in_valid[k] && in_ready[k] at a rising clk.
REQ-018 At most one in_ready bit is high in any cycle; in_ready[k] = can_accept && (k == granted channel).
REQ-019 MODE 0: granted channel = sel; if sel >= NUM_IN, no channel is granted and all in_ready are 0.
REQ-020 MODE 0: in_ready[sel] is independent of in_valid[sel]; a change to sel between cycles takes effect immediately.
REQ-021 MODE 1: a round-robin pointer rr_ptr (SEL_W bits) is kept; the granted channel is the first k with in_valid[k] high, searching rr_ptr, rr_ptr+1, ... modulo NUM_IN.
REQ-022 MODE 1: with no in_valid high, no channel is granted and all in_ready are 0.
REQ-023 MODE 1: after a transfer on channel g, rr_ptr <= (g+1) mod NUM_IN, wrapping from NUM_IN-1 to 0; without a transfer, rr_ptr holds.
REQ-024 On a transfer, out_data <= channel data, out_chan <= channel index, and out_valid <= 1.
REQ-025 With out_valid && out_ready and no new transfer, out_valid <= 0; out_data and out_chan hold their values.
REQ-026 Simultaneous drain and fill (out_valid && out_ready && transfer): new word loaded, out_valid stays 1, no bubble, full throughput of one word per cycle.
REQ-027 Backpressure (out_valid && !out_ready): out_data, out_chan and out_valid hold stable; all in_ready are 0.
REQ-028 No word is duplicated or dropped; output order equals transfer order.

Reset
REQ-029 While rst_n = 0: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0, all in_ready = 0.
REQ-030 Reset asserted mid-transfer discards the held word with no output handshake; the first transfer after release follows REQ-015.

Verification
REQ-031 MODE 0, in0=5, in1=10, out_ready=1, sel=0 then sel=1 -> out_data 5 (out_chan 0) one cycle after each valid transfer, then 10 (out_chan 1).
REQ-032 MODE 0, out_ready=0 for 3 cycles after loading 5 -> out_data stays 5, out_valid stays 1, in_ready all 0; out_ready=1 -> drain with the next word loaded in the same cycle.
REQ-033 MODE 1, NUM_IN=4, all in_valid=1, data k = 100+k, out_ready=1 -> out_chan sequence 0,1,2,3,0 with out_data 100,101,102,103,100.
REQ-034 MODE 1, only channels 1 and 3 valid, rr_ptr=2 -> channel 3 granted first, then 1 (wrap-around), then 3.
REQ-035 MODE 0, sel=4 with NUM_IN=4 (legal 3-bit select only if NUM_IN=5+; use NUM_IN=5 with sel=5..7) -> in_ready all 0, out_valid stays 0.
REQ-036 rst_n driven low while out_valid=1 holding 10 -> out_valid, out_data, out_chan read 0 immediately (asynchronous), rr_ptr reads 0 after release.
